phy_reg_free_list: RTL and testbench

PHY_REG_FREE_LIST -- requirements
Module: phy_reg_free_list

---
 rtl/mips_core_pkg.sv | 24 ++
 rtl/fl_ptr.sv | 39 +++
 rtl/phy_reg_free_list.sv | 156 +++++++++++++++
 tb/tb_phy_reg_free_list.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
// Shared core-wide sizing for the rename map, register file and free list.
//   NUM_PHY_REGS  : physical register file depth
//   NUM_ARCH_REGS : architectural register count
//   PREG_W        : width of a physical register tag
//   phy_reg_t     : physical register tag type
//   fl_ptr_w()    : width of a wrap-bit pointer over a ring of given depth
// ---------------------------------------------------------------------------
package mips_core_pkg;

  localparam int NUM_PHY_REGS  = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PREG_W        = $clog2(NUM_PHY_REGS);

  typedef logic [PREG_W-1:0] phy_reg_t;

  // One index bit per ring slot plus one wrap bit, so that a full ring and
  // an empty ring are distinguishable when the indices coincide.
  function automatic int fl_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fl_ptr.sv
// ---------------------------------------------------------------------------
// fl_ptr
// Wrap-bit ring pointer with synchronous reset, load and increment.
// Arithmetic is natural modulo 2**W, i.e. modulo twice the ring depth.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, loads rst_val
//   rst_val  : value taken on reset
//   inc      : advance the pointer by one
//   load     : replace the pointer with load_val (wins over inc)
//   load_val : value taken on load
//   ptr      : current pointer value
// ---------------------------------------------------------------------------
module fl_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= rst_val;
    end else if (load) begin
      ptr_reg <= load_val;
    end else if (inc) begin
      ptr_reg <= ptr_reg + W'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/phy_reg_free_list.sv
// ---------------------------------------------------------------------------
// phy_reg_free_list
// Circular free list of physical registers for register renaming.
// Three wrap-bit pointers walk one ring:
//   [retire_head, spec_head) : pregs handed out but not yet retired
//   [spec_head,   tail)      : pregs free for speculative allocation
// A flush rewinds spec_head to retire_head, returning every in-flight preg.
// The number of entries (FL_DEPTH) must be a power of two.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : synchronous active-low reset, overrides everything
//   alloc_req       : rename wants one destination preg
//   alloc_gnt       : request granted this cycle (combinational)
//   alloc_preg      : granted preg, valid while alloc_gnt=1
//   commit_valid    : ROB retires an instruction with a destination
//   commit_old_preg : previous mapping released at retire (0 is never freed)
//   flush           : mispredict / exception squash
//   free_count      : speculative free entries
//   empty           : free_count == 0
//   overflow_err    : sticky protocol error (dropped free or commit)
// ---------------------------------------------------------------------------
module phy_reg_free_list
  import mips_core_pkg::fl_ptr_w;
#(
  parameter int  NUM_PHY_REGS  = mips_core_pkg::NUM_PHY_REGS,
  parameter int  NUM_ARCH_REGS = mips_core_pkg::NUM_ARCH_REGS,
  localparam int FL_DEPTH      = NUM_PHY_REGS - NUM_ARCH_REGS,
  localparam int PREG_W        = $clog2(NUM_PHY_REGS),
  localparam int PTR_W         = fl_ptr_w(FL_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              commit_valid,
  input  logic [PREG_W-1:0] commit_old_preg,
  input  logic              flush,
  output logic [PTR_W-1:0]  free_count,
  output logic              empty,
  output logic              overflow_err
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]  spec_head;
  logic [PTR_W-1:0]  retire_head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  spec_load_val;

  logic [PREG_W-1:0] fifo_reg [FL_DEPTH];
  logic [FL_DEPTH-1:0] wr_sel;
  logic              overflow_err_reg;

  logic full;
  logic none_outstanding;
  logic commit_drop;
  logic commit_ok;
  logic free_wr;
  logic spec_inc;

  // -------------------------------------------------------------------------
  // Occupancy. The wrap bit makes the plain difference exact: equal indices
  // with different wrap bits give FL_DEPTH (full), identical pointers give 0.
  // -------------------------------------------------------------------------
  assign free_count = tail - spec_head;
  assign empty      = (free_count == '0);
  assign full       = (free_count == PTR_W'(FL_DEPTH));

  // No bypass from the commit port: a grant only ever comes from the ring.
  assign alloc_gnt  = alloc_req && !empty;
  assign alloc_preg = fifo_reg[spec_head[IDX_W-1:0]];

  // -------------------------------------------------------------------------
  // Commit handling. A commit with nothing in flight has no allocation to
  // retire; a free into a full ring would overwrite the next grant. Both are
  // dropped and flagged. Preg 0 retires without being recycled.
  // -------------------------------------------------------------------------
  assign none_outstanding = (retire_head == spec_head);
  assign commit_drop = commit_valid &&
                       (none_outstanding || ((commit_old_preg != '0) && full));
  assign commit_ok   = commit_valid && !commit_drop;
  assign free_wr     = commit_ok && (commit_old_preg != '0);

  // A flush discards this cycle's alloc and rewinds to the retire point,
  // which itself moves forward if a commit lands in the same cycle.
  assign spec_inc      = alloc_gnt && !flush;
  assign spec_load_val = retire_head + {{(PTR_W-1){1'b0}}, commit_ok};

  fl_ptr #(.W(PTR_W)) u_spec_head (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val  ('0),
    .inc      (spec_inc),
    .load     (flush),
    .load_val (spec_load_val),
    .ptr      (spec_head)
  );

  fl_ptr #(.W(PTR_W)) u_retire_head (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val  ('0),
    .inc      (commit_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (retire_head)
  );

  // Tail starts one full lap ahead: index 0 with the wrap bit set.
  fl_ptr #(.W(PTR_W)) u_tail (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val  (PTR_W'(FL_DEPTH)),
    .inc      (free_wr),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  // -------------------------------------------------------------------------
  // Ring storage. Reset seeds it with every non-architectural preg in order.
  // Reads are combinational, so the grant has zero latency.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = free_wr && (tail[IDX_W-1:0] == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fifo_reg[i] <= PREG_W'(NUM_ARCH_REGS + i);
      end
    end else begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (wr_sel[i]) begin
          fifo_reg[i] <= commit_old_preg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err_reg <= 1'b0;
    end else if (commit_drop) begin
      overflow_err_reg <= 1'b1;
    end
  end

  assign overflow_err = overflow_err_reg;

endmodule

// File: tb/tb_phy_reg_free_list.sv
module tb_phy_reg_free_list;

  localparam int NAR = 32;
  localparam int FLD = 32;
  localparam int PW  = 6;
  localparam int CW  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          commit_valid = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] commit_old_preg = '0;
  logic          alloc_gnt;
  logic [PW-1:0] alloc_preg;
  logic [CW-1:0] free_count;
  logic          empty;
  logic          overflow_err;

  phy_reg_free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_preg      (alloc_preg),
    .commit_valid    (commit_valid),
    .commit_old_preg (commit_old_preg),
    .flush           (flush),
    .free_count      (free_count),
    .empty           (empty),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        id;
    bit        gnt;
    int        preg;
    int        fc;
    bit        emp;
    bit        err;
    bit [63:0] busy;   // pregs that are in flight or architectural
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model: ordered free pool, ordered in-flight list, and the set
  // of architectural pregs that may legally be released by a commit.
  int free_q[$];
  int infl_q[$];
  int arch_q[$];
  bit m_err;

  function automatic void chk(string name, logic [31:0] act, int req);
    checks++;
    if ($isunknown(act) || act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    arch_q.delete();
    for (int i = 0; i < FLD; i++) free_q.push_back(NAR + i);
    for (int i = 1; i < NAR; i++) arch_q.push_back(i);
    m_err = 1'b0;
  endtask

  task automatic do_reset(input bit a, input bit cv, input int old, input bit fl);
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req = a;
    commit_valid = cv;
    commit_old_preg = PW'(old);
    flush = fl;
    model_reset();
  endtask

  task automatic cycle(input bit a, input bit cv, input int old, input bit fl);
    exp_t e;
    bit   accept;
    int   retired;
    @(negedge clk);
    rst_n = 1'b1;
    alloc_req = a;
    commit_valid = cv;
    commit_old_preg = PW'(old);
    flush = fl;

    e.id   = txn++;
    e.gnt  = a && (free_q.size() > 0);
    e.preg = (free_q.size() > 0) ? free_q[0] : 0;
    e.fc   = free_q.size();
    e.emp  = (free_q.size() == 0);
    e.err  = m_err;
    e.busy = '1;
    foreach (free_q[i]) e.busy[free_q[i]] = 1'b0;
    exp_q.push_back(e);

    // state after the edge
    accept = cv && (infl_q.size() > 0) && !((old != 0) && (free_q.size() == FLD));
    if (cv && !accept) m_err = 1'b1;
    if (e.gnt && !fl) infl_q.push_back(free_q.pop_front());
    if (accept) begin
      retired = infl_q.pop_front();
      arch_q.push_back(retired);
      if (old != 0) begin
        free_q.push_back(old);
        for (int i = 0; i < arch_q.size(); i++) begin
          if (arch_q[i] == old) begin
            arch_q.delete(i);
            break;
          end
        end
      end
    end
    if (fl) begin
      while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
    end
  endtask

  // Monitor: pops one expectation per issued cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d gnt=%0b preg=%0d free=%0d empty=%0b err=%0b",
                 e.id, alloc_gnt, alloc_preg, free_count, empty, overflow_err);
        chk("alloc_gnt", 32'(alloc_gnt), int'(e.gnt));
        if (e.gnt) chk("alloc_preg", 32'(alloc_preg), e.preg);
        chk("free_count", 32'(free_count), e.fc);
        chk("empty", 32'(empty), int'(e.emp));
        chk("overflow_err", 32'(overflow_err), int'(e.err));
        if (alloc_gnt === 1'b1 && !$isunknown(alloc_preg))
          chk("no_dup_preg", 32'(e.busy[alloc_preg]), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int old;
    bit a, cv, fl;

    // 32 grants in order, then the list runs dry
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 33; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // allocs, one commit, flush rewinds to just past the retire point
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 5, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // free into an empty list is not bypassed to a same-cycle request
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 7, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // preg 0 retires without being recycled
    do_reset(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // free into a full list is dropped; error is sticky until reset
    do_reset(0, 0, 0, 0);
    cycle(0, 1, 9, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    do_reset(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // flush with same-cycle commit and alloc
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 3, 1);
    cycle(1, 0, 0, 0);

    // random traffic
    do_reset(0, 0, 0, 0);
    for (int n = 0; n < 1000; n++) begin
      a  = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 4);
      cv = (infl_q.size() > 0) ? ($urandom_range(0, 99) < 40)
                               : ($urandom_range(0, 99) < 2);
      if (arch_q.size() == 0 || $urandom_range(0, 63) == 0) old = 0;
      else old = arch_q[$urandom_range(0, arch_q.size() - 1)];
      cycle(a, cv, old, fl);
    end

    // reset wins over a simultaneous alloc, commit and flush
    do_reset(1, 1, 12, 1);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
